// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES encrypt/decrypt engine, ROUNDS_PER_CYCLE rounds per clock, valid/ready on both sides.
module des_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic [63:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);
  localparam int NCYC = 16 / ROUNDS_PER_CYCLE;
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
  // Tables use DES numbering: table entry n selects bit (width-n) of the source vector.
  function automatic logic [63:0] ip_fn(input logic [63:0] x);
    for (int i = 0; i < 64; i++) ip_fn[63-i] = x[64-IP_T[i]];
  endfunction
  function automatic logic [63:0] fp_fn(input logic [63:0] x);
    for (int i = 0; i < 64; i++) fp_fn[63-i] = x[64-FP_T[i]];
  endfunction
  function automatic logic [55:0] pc1_fn(input logic [63:0] x);
    for (int i = 0; i < 56; i++) pc1_fn[55-i] = x[64-PC1_T[i]];
  endfunction
  function automatic logic [47:0] pc2_fn(input logic [55:0] x);
    for (int i = 0; i < 48; i++) pc2_fn[47-i] = x[56-PC2_T[i]];
  endfunction
  function automatic logic [31:0] f_fn(input logic [31:0] x, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [5:0] b;
    for (int i = 0; i < 48; i++) e[47-i] = x[32-E_T[i]];
    e = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b = e[47-6*i -: 6];
      s[31-4*i -: 4] = 4'(SB[i][{b[5], b[0], b[4:1]}]);
    end
    for (int i = 0; i < 32; i++) f_fn[31-i] = s[32-P_T[i]];
  endfunction
  function automatic logic [27:0] rot(input logic [27:0] x, input logic [1:0] n, input logic rt);
    return rt ? (n == 2'd2 ? {x[1:0], x[27:2]} : n == 2'd1 ? {x[0], x[27:1]} : x)
              : (n == 2'd2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]});
  endfunction
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t state, state_n;
  logic [31:0] l, r, l_n, r_n, t;
  logic [27:0] c, d, c_n, d_n;
  logic [3:0] cnt;
  logic [4:0] idx;
  logic [1:0] sh;
  logic mode, last;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign last = cnt == 4'(NCYC - 1);
  always_comb begin
    state_n = state == IDLE ? (in_valid ? ROUND : IDLE)
            : state == ROUND ? (last ? DONE : ROUND)
            : (out_ready ? IDLE : DONE);
  end
  // Key schedule shift happens before each round; decrypt walks it backwards starting from K16.
  always_comb begin
    c_n = c;
    d_n = d;
    l_n = l;
    r_n = r;
    t = '0;
    idx = '0;
    sh = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      idx = 5'(int'(cnt) * ROUNDS_PER_CYCLE + j);
      sh = idx == 5'd0 ? (mode ? 2'd0 : 2'd1) : (idx == 5'd1 || idx == 5'd8 || idx == 5'd15) ? 2'd1 : 2'd2;
      c_n = rot(c_n, sh, mode);
      d_n = rot(d_n, sh, mode);
      t = r_n;
      r_n = l_n ^ f_fn(r_n, pc2_fn({c_n, d_n}));
      l_n = t;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {l, r, c, d} <= '0;
      cnt <= '0;
      mode <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        {l, r} <= ip_fn(data_in);
        {c, d} <= pc1_fn(key);
        mode <= decrypt;
        cnt <= '0;
      end else if (state == ROUND) begin
        {l, r, c, d} <= {l_n, r_n, c_n, d_n};
        cnt <= cnt + 4'd1;
        if (last) data_out <= fp_fn({r_n, l_n});
      end
    end
  end
endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: directed known-answer checks of des_iter_core for every legal ROUNDS_PER_CYCLE.
module tb_des_iter_core;
  localparam int NI = 5;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1, P1 = 64'h0123456789ABCDEF, C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73, P2 = 64'h8787878787878787, C2 = 64'h0;
  logic clk = 1'b0, rst, dec;
  logic [63:0] key, din;
  logic [NI-1:0] iv, ir, ov, ordy, bsy;
  logic [63:0] dout [NI];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .decrypt(dec), .key(key),
      .data_in(din), .out_valid(ov[g]), .out_ready(ordy[g]), .data_out(dout[g]), .busy(bsy[g]));
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Drives one request into instance k; scrambles inputs right after acceptance.
  task automatic run(input int k, input logic dc, input logic [63:0] kk, input logic [63:0] di,
                     input logic [63:0] ex, input logic bp, input string tag);
    int lat;
    @(negedge clk);
    ordy[k] = !bp;
    chk({tag, " in_ready"}, 64'(ir[k]), 64'd1);
    iv[k] = 1'b1; key = kk; din = di; dec = dc;
    @(posedge clk);
    lat = 1;
    #1 iv[k] = bp; key = ~kk; din = ~di; dec = ~dc;
    @(negedge clk);
    chk({tag, " busy"}, 64'(bsy[k]), 64'd1);
    while (!ov[k] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 64'(lat), 64'(16 / (1 << k) + 1));
    chk({tag, " data"}, dout[k], ex);
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        din = {$urandom, $urandom};
        @(negedge clk);
        chk({tag, " bp data"}, dout[k], ex);
        chk({tag, " bp in_ready"}, 64'(ir[k]), 64'd0);
      end
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
    end
    @(negedge clk);
    chk({tag, " out_valid drop"}, 64'(ov[k]), 64'd0);
    chk({tag, " in_ready back"}, 64'(ir[k]), 64'd1);
    chk({tag, " data held"}, dout[k], ex);
  endtask
  initial begin
    rst = 1'b1; iv = '0; ordy = '1; key = '0; din = '0; dec = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(ir), 64'h1F);
    chk("reset out_valid", 64'(ov), 64'h0);
    chk("reset busy", 64'(bsy), 64'h0);
    chk("reset data_out r1", dout[0], 64'h0);
    chk("reset data_out r16", dout[4], 64'h0);
    rst = 1'b0;
    run(0, 1'b0, K1, P1, C1, 1'b0, "r1 enc");
    run(0, 1'b1, K1, C1, P1, 1'b0, "r1 dec");
    for (int k = 1; k < NI; k++) begin
      run(k, 1'b0, K2, P2, C2, 1'b0, $sformatf("r%0d enc", 1 << k));
      run(k, 1'b1, K2, C2, P2, 1'b0, $sformatf("r%0d dec", 1 << k));
    end
    run(0, 1'b0, K1, P1, C1, 1'b1, "r1 backpressure");
    @(negedge clk);
    iv[0] = 1'b1; key = K1; din = C1; dec = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort busy before", 64'(bsy[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort out_valid", 64'(ov[0]), 64'd0);
    chk("abort data_out", dout[0], 64'h0);
    chk("abort in_ready", 64'(ir[0]), 64'd1);
    chk("abort busy", 64'(bsy[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 1'b0, K1, P1, C1, 1'b0, "r1 after abort");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
